// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and constants: FSM state encoding, BCD digit width,
// digit radices and the preset-digit clamp used when loading.
package stopwatch_pkg;

  localparam int BCD_W          = 4;
  localparam int RADIX_DEC      = 10;
  localparam int RADIX_SEC_TENS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Force an out-of-range BCD digit down to the largest legal value for its radix
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d, input int radix);
    logic [BCD_W-1:0] top;
    top = BCD_W'(radix - 1);
    return (d > top) ? top : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown: loadable, decrements when a borrow reaches it,
// and wraps to RADIX-1 while passing the borrow on when it is already zero.
module bcd_down_digit
  import stopwatch_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  always_ff @(posedge clk) begin
    if (!r_n)
      digit <= '0;
    else if (load)
      digit <= load_val;
    else if (dec && borrow_in)
      digit <= (digit == '0) ? BCD_W'(RADIX - 1) : digit - 1'b1;
  end

  assign borrow_out = borrow_in && (digit == '0);

endmodule

// File: rtl/stopwatch_down_counter.sv
// Multi-digit BCD countdown timer for the stopwatch's timer mode.
// Optional STOPWATCH_DOWN_AUTO_RELOAD_EN restarts from the last preset on terminal count.
module stopwatch_down_counter
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int MMSS   = 1
) (
  input  logic                    clk,
  input  logic                    r_n,
  input  logic                    tick,
  input  logic                    s,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] preset,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    zero,
  output logic                    done
);

  localparam int CW = BCD_W * DIGITS;
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t          state, state_nx;
  logic            s_q, s_rise;
  logic            done_q;
  logic [CW-1:0]   reload_q;
  logic [CW-1:0]   preset_san;
  logic [CW-1:0]   digit_val;
  logic [DIGITS-1:0] borrow;
  logic            load_ok, dec, term, reload_hit, digit_load;

  assign s_rise  = s && !s_q;
  assign load_ok = load && (state != RUN);
  assign dec     = (state == RUN) && tick && !s_rise && !zero;
  assign term    = dec && (count == ONE);

`ifdef STOPWATCH_DOWN_AUTO_RELOAD_EN
  assign reload_hit = term && (reload_q != '0);
`else
  assign reload_hit = 1'b0;
`endif

  assign digit_load = load_ok || reload_hit;
  assign digit_val  = load_ok ? preset_san : reload_q;

  // A borrow only leaves the top digit when every digit is zero
  assign zero = borrow[DIGITS-1];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam int R = (MMSS != 0 && i == 1) ? RADIX_SEC_TENS : RADIX_DEC;
    logic bin;
    assign bin = (i == 0) ? 1'b1 : borrow[(i == 0) ? 0 : i - 1];
    assign preset_san[i*BCD_W +: BCD_W] = clamp_digit(preset[i*BCD_W +: BCD_W], R);

    bcd_down_digit #(.RADIX(R)) u_digit (
      .clk       (clk),
      .r_n       (r_n),
      .load      (digit_load),
      .load_val  (digit_val[i*BCD_W +: BCD_W]),
      .dec       (dec),
      .borrow_in (bin),
      .digit     (count[i*BCD_W +: BCD_W]),
      .borrow_out(borrow[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!r_n) begin
      state    <= IDLE;
      s_q      <= 1'b0;
      done_q   <= 1'b0;
      reload_q <= '0;
    end else begin
      state  <= state_nx;
      s_q    <= s;
      done_q <= term;
      if (load_ok)
        reload_q <= preset_san;
    end
  end

  // Load outside RUN overrides any start/stop edge in the same cycle
  always_comb begin
    state_nx = state;
    if (load_ok) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (s_rise && !zero) state_nx = RUN;
        RUN:     if (s_rise) state_nx = PAUSE;
                 else if (term) state_nx = reload_hit ? RUN : DONE;
        PAUSE:   if (s_rise) state_nx = RUN;
        DONE:    if (s_rise) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state == RUN);
    done    = done_q;
  end

endmodule

// File: tb/tb_stopwatch_down_counter.sv
// Directed self-checking bench for stopwatch_down_counter (DIGITS=4, MMSS=1).
module tb_stopwatch_down_counter;

  logic        clk = 1'b0;
  logic        r_n = 1'b0;
  logic        tick = 1'b0;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = '0;
  logic [15:0] count;
  logic        running, zero, done;
  int          compared = 0;
  int          mismatched = 0;

  stopwatch_down_counter #(.DIGITS(4), .MMSS(1)) dut (
    .clk(clk), .r_n(r_n), .tick(tick), .s(s), .load(load), .preset(preset),
    .count(count), .running(running), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic press();
    s = 1'b1; cyc(); s = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    preset = v; load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic test_reset();
    r_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = 1'($urandom); tick = 1'($urandom); load = 1'($urandom); preset = 16'($urandom);
      cyc();
    end
    s = 0; tick = 0; load = 0; preset = 0;
    compared++;
    if (count !== 16'h0000 || zero !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset: got count=%h zero=%b run=%b done=%b want 0000 1 0 0", count, zero, running, done);
    end
    r_n = 1'b1;
    cyc();
  endtask

  task automatic test_load_borrow();
    int pulses = 0;
    do_load(16'h0100);
    compared++;
    if (count !== 16'h0100 || running !== 1'b0 || zero !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_0100: got count=%h run=%b zero=%b want 0100 0 0", count, running, zero);
    end
    press();
    compared++;
    if (running !== 1'b1 || count !== 16'h0100) begin
      mismatched++;
      $display("[TB] FAIL start: got run=%b count=%h want 1 0100", running, count);
    end
    tick = 1'b1; cyc(); tick = 1'b0;
    compared++;
    if (count !== 16'h0059) begin
      mismatched++;
      $display("[TB] FAIL borrow_0059: got %h want 0059", count);
    end
    for (int i = 0; i < 9; i++) begin
      tick = 1'b1; cyc(); pulses += int'(done);
    end
    compared++;
    if (count !== 16'h0050) begin
      mismatched++;
      $display("[TB] FAIL count_0050: got %h want 0050", count);
    end
    tick = 1'b1; cyc(); pulses += int'(done);
    compared++;
    if (count !== 16'h0049) begin
      mismatched++;
      $display("[TB] FAIL borrow_0049: got %h want 0049", count);
    end
    for (int i = 0; i < 48; i++) begin
      tick = 1'b1; cyc(); pulses += int'(done);
    end
    compared++;
    if (count !== 16'h0001 || running !== 1'b1 || pulses != 0) begin
      mismatched++;
      $display("[TB] FAIL count_0001: got count=%h run=%b pulses=%0d want 0001 1 0", count, running, pulses);
    end
    tick = 1'b1; cyc(); pulses += int'(done);
    compared++;
    if (count !== 16'h0000 || running !== 1'b0 || zero !== 1'b1 || done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL terminal: got count=%h run=%b zero=%b done=%b want 0000 0 1 1", count, running, zero, done);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); pulses += int'(done);
    end
    tick = 1'b0;
    compared++;
    if (pulses != 1 || count !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL done_once: got pulses=%0d count=%h want 1 0000", pulses, count);
    end
  endtask

  task automatic test_done_ack();
    press();
    compared++;
    if (running !== 1'b0 || count !== 16'h0000 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL done_ack: got run=%b count=%h done=%b want 0 0000 0", running, count, done);
    end
    cyc();
    press();
    compared++;
    if (running !== 1'b0 || count !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL idle_zero_start: got run=%b count=%h want 0 0000", running, count);
    end
  endtask

  task automatic test_sanitise();
    do_load(16'h00AF);
    compared++;
    if (count !== 16'h0059) begin
      mismatched++;
      $display("[TB] FAIL sanitise_00AF: got %h want 0059", count);
    end
    do_load(16'h9F9F);
    compared++;
    if (count !== 16'h9959) begin
      mismatched++;
      $display("[TB] FAIL sanitise_9F9F: got %h want 9959", count);
    end
  endtask

  task automatic test_pause_collision();
    do_load(16'h0005);
    press();
    cyc();
    s = 1'b1; tick = 1'b1; cyc(); s = 1'b0;
    compared++;
    if (count !== 16'h0005 || running !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL collision: got count=%h run=%b want 0005 0", count, running);
    end
    cyc(3);
    compared++;
    if (count !== 16'h0005 || running !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL pause_hold: got count=%h run=%b want 0005 0", count, running);
    end
    tick = 1'b0;
    press();
    compared++;
    if (running !== 1'b1 || count !== 16'h0005) begin
      mismatched++;
      $display("[TB] FAIL resume: got run=%b count=%h want 1 0005", running, count);
    end
    tick = 1'b1; cyc(); tick = 1'b0;
    compared++;
    if (count !== 16'h0004) begin
      mismatched++;
      $display("[TB] FAIL resume_dec: got %h want 0004", count);
    end
  endtask

  task automatic test_guards();
    do_load(16'h0100);
    compared++;
    if (count !== 16'h0004 || running !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL load_in_run: got count=%h run=%b want 0004 1", count, running);
    end
    r_n = 1'b0; cyc(); r_n = 1'b1;
    compared++;
    if (count !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_run: got count=%h run=%b done=%b want 0000 0 0", count, running, done);
    end
    cyc();
    // Load and a start edge together: load wins and the block stays idle
    s = 1'b1; do_load(16'h0003); s = 1'b0;
    compared++;
    if (count !== 16'h0003 || running !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_priority: got count=%h run=%b want 0003 0", count, running);
    end
  endtask

  task automatic test_auto_reload();
    int pulses = 0;
    do_load(16'h0003);
    press();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; cyc(); pulses += int'(done);
    end
    tick = 1'b0;
`ifdef STOPWATCH_DOWN_AUTO_RELOAD_EN
    compared++;
    if (pulses != 1 || count !== 16'h0003 || running !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL auto_reload: got pulses=%0d count=%h run=%b want 1 0003 1", pulses, count, running);
    end
`else
    compared++;
    if (pulses != 1 || count !== 16'h0000 || running !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL no_reload: got pulses=%0d count=%h run=%b want 1 0000 0", pulses, count, running);
    end
`endif
  endtask

  initial begin
    cyc();
    test_reset();
    test_load_borrow();
    test_done_ack();
    test_sanitise();
    test_pause_collision();
    test_guards();
    test_auto_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
